lmc_core_p: RTL and testbench

- Parametrised successor of the team's LMC datapath (program counter, program RAM, data RAM, accumulator).
- Replaces the per-field strobes with a single-clock fetch/execute FSM, a decoded opcode set with flags and branches, and handshaked IN/OUT ports.
- Program RAM is loaded through a write port while the core is stopped, then run from address 0.
- Top-level CPU of the LMC board; the I/O ports connect to switches and LEDs.

---
 rtl/lmc_core_p.sv | 174 +++++++++++++++++
 tb/tb_lmc_core_p.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmc_core_p.sv
// lmc_core_p: LMC CPU with a fetch/execute FSM, Z/C flags, branches
// and valid/ready IN/OUT ports; program RAM is loaded while stopped.
module lmc_core_p #(
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH = 4,
    localparam int INSTR_WIDTH = ADDR_WIDTH + 4
) (
    input  logic                   timer555,
    input  logic                   reset_count,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   run,
    input  logic [ACC_WIDTH-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  counter,
    output logic [ACC_WIDTH-1:0]   Acc,
    output logic                   flag_z,
    output logic                   flag_c,
    output logic                   halted,
    output logic                   busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [3:0] OP_HLT = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_LDA = 4'd2;
    localparam logic [3:0] OP_STA = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_BRZ = 4'd7;
    localparam logic [3:0] OP_BRC = 4'd8;
    localparam logic [3:0] OP_IN  = 4'd9;
    localparam logic [3:0] OP_OUT = 4'd10;

    typedef enum logic [2:0] {
        IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT
    } state_t;

    state_t state, state_d;

    logic [INSTR_WIDTH-1:0] prog_mem [DEPTH];
    logic [ACC_WIDTH-1:0]   data_mem [DEPTH];

    logic [INSTR_WIDTH-1:0] ir, ir_d;
    logic [ADDR_WIDTH-1:0]  pc_d;
    logic [ACC_WIDTH-1:0]   acc_d, out_d;
    logic                   z_d, c_d;

    logic [3:0]             opcode;
    logic [ADDR_WIDTH-1:0]  operand;
    logic [ACC_WIDTH-1:0]   mem_rd;
    logic [ACC_WIDTH-1:0]   imm;
    logic [ACC_WIDTH:0]     sum, diff;
    logic                   stopped;
    logic                   dmem_we;

    assign opcode  = ir[INSTR_WIDTH-1 -: 4];
    assign operand = ir[ADDR_WIDTH-1:0];
    assign mem_rd  = data_mem[operand];
    assign imm     = ACC_WIDTH'(operand);

    // Extra top bit carries out of ADD and flags a borrow on SUB.
    assign sum  = {1'b0, Acc} + {1'b0, mem_rd};
    assign diff = {1'b0, Acc} - {1'b0, mem_rd};

    assign stopped   = (state == IDLE) || (state == HALT);
    assign dmem_we   = (state == EXEC) && (opcode == OP_STA);
    assign in_ready  = (state == WAIT_IN);
    assign out_valid = (state == WAIT_OUT);
    assign halted    = (state == HALT);
    assign busy      = !stopped;

    always_comb begin
        state_d = state;
        pc_d    = counter;
        ir_d    = ir;
        acc_d   = Acc;
        z_d     = flag_z;
        c_d     = flag_c;
        out_d   = out_data;
        unique case (state)
            IDLE, HALT: begin
                if (run) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = prog_mem[counter];
                pc_d    = counter + ADDR_WIDTH'(1);
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_HLT: state_d = HALT;
                    OP_LDI: begin
                        acc_d = imm;
                        z_d   = (imm == '0);
                    end
                    OP_LDA: begin
                        acc_d = mem_rd;
                        z_d   = (mem_rd == '0);
                    end
                    OP_ADD: begin
                        acc_d = sum[ACC_WIDTH-1:0];
                        c_d   = sum[ACC_WIDTH];
                        z_d   = (sum[ACC_WIDTH-1:0] == '0);
                    end
                    OP_SUB: begin
                        acc_d = diff[ACC_WIDTH-1:0];
                        c_d   = diff[ACC_WIDTH];
                        z_d   = (diff[ACC_WIDTH-1:0] == '0);
                    end
                    OP_JMP: pc_d = operand;
                    OP_BRZ: if (flag_z) pc_d = operand;
                    OP_BRC: if (flag_c) pc_d = operand;
                    OP_IN:  state_d = WAIT_IN;
                    OP_OUT: begin
                        out_d   = Acc;
                        state_d = WAIT_OUT;
                    end
                    default: ;
                endcase
            end
            WAIT_IN: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    z_d     = (in_data == '0);
                    state_d = FETCH;
                end
            end
            WAIT_OUT: begin
                if (out_ready) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge timer555) begin
        if (reset_count) begin
            state    <= IDLE;
            counter  <= '0;
            ir       <= '0;
            Acc      <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            out_data <= '0;
        end else begin
            state    <= state_d;
            counter  <= pc_d;
            ir       <= ir_d;
            Acc      <= acc_d;
            flag_z   <= z_d;
            flag_c   <= c_d;
            out_data <= out_d;
        end
    end

    // RAM contents survive reset; reset only blocks writes.
    always_ff @(posedge timer555) begin
        if (!reset_count) begin
            if (stopped && prog_we) prog_mem[prog_addr] <= prog_data;
            if (dmem_we) data_mem[operand] <= Acc;
        end
    end

endmodule

// File: tb/tb_lmc_core_p.sv
// tb_lmc_core_p: directed vector table, handshake/reset sequences and
// random programs checked against an instruction-level model.
module tb_lmc_core_p;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int IW = AW + 4;
    localparam int N = 1 << AW;
    localparam int DM = 1 << DW;
    localparam int NV = 6;

    logic          timer555 = 1'b0;
    logic          reset_count, prog_we, run, in_valid, out_ready;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, flag_z, flag_c, halted, busy;
    logic [DW-1:0] out_data, Acc;
    logic [AW-1:0] counter;

    lmc_core_p #(.ADDR_WIDTH(AW), .ACC_WIDTH(DW)) dut (
        .timer555(timer555), .reset_count(reset_count),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .run(run), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .counter(counter), .Acc(Acc),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .busy(busy)
    );

    always #5 timer555 = ~timer555;

    typedef struct {
        logic [N-1:0][IW-1:0] prog;
        int acc, z, c, cnt, out, nvalid, wfrom, wto, nwatch;
    } vec_t;

    vec_t vecs [NV];
    logic [N-1:0][IW-1:0] prog;
    int checks = 0;
    int fails = 0;
    int outs [$];
    int expq [$];
    int inq [64];
    int mprog [N];
    int mdmem [N];
    int macc, mz, mc, mpc;

    function automatic logic [IW-1:0] ins(input int op, input int n);
        return {4'(op), AW'(n)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge timer555);
        #1;
    endtask

    task automatic load_prog(input logic [N-1:0][IW-1:0] p);
        for (int i = 0; i < N; i++) begin
            prog_we = 1'b1;
            prog_addr = AW'(i);
            prog_data = p[i];
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic run_core(input int budget, input bit rnd, output bit to,
                            output int nvalid, output int nwatch,
                            input int wfrom, input int wto);
        int prev, idx;
        bit take;
        outs.delete();
        idx = 0;
        nvalid = 0;
        nwatch = 0;
        to = 1'b1;
        prev = int'(counter);
        run = 1'b1;
        step();
        run = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (rnd) begin
                in_valid = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                in_data = DW'(inq[idx]);
            end
            @(negedge timer555);
            if (prev == wfrom && int'(counter) == wto) nwatch++;
            prev = int'(counter);
            if (out_valid) nvalid++;
            if (out_valid && out_ready) outs.push_back(int'(out_data));
            take = in_ready && in_valid;
            if (halted) begin
                to = 1'b0;
                break;
            end
            step();
            if (take) idx++;
        end
        step();
    endtask

    // Instruction-level reference: executes the ISA directly on ints.
    function automatic void model_run();
        int pc, op, n, t, ii;
        pc = 0;
        ii = 0;
        expq.delete();
        for (int g = 0; g < 1000; g++) begin
            op = mprog[pc] / N;
            n = mprog[pc] % N;
            pc = (pc + 1) % N;
            if (op == 0) break;
            case (op)
                1: begin macc = n % DM; mz = int'(macc == 0); end
                2: begin macc = mdmem[n]; mz = int'(macc == 0); end
                3: mdmem[n] = macc;
                4: begin
                    t = macc + mdmem[n];
                    mc = int'(t >= DM);
                    macc = t % DM;
                    mz = int'(macc == 0);
                end
                5: begin
                    mc = int'(macc < mdmem[n]);
                    macc = (macc - mdmem[n] + DM) % DM;
                    mz = int'(macc == 0);
                end
                6: pc = n;
                7: if (mz != 0) pc = n;
                8: if (mc != 0) pc = n;
                9: begin macc = inq[ii]; ii++; mz = int'(macc == 0); end
                10: expq.push_back(macc);
                default: ;
            endcase
        end
        mpc = pc;
    endfunction

    task automatic model_case(input string tag, input bit rnd);
        bit to;
        int nv, nw;
        load_prog(prog);
        for (int i = 0; i < N; i++) mprog[i] = int'(prog[i]);
        model_run();
        run_core(600, rnd, to, nv, nw, 0, 0);
        chk({tag, " timeout"}, int'(to), 0);
        chk({tag, " Acc"}, int'(Acc), macc);
        chk({tag, " flag_z"}, int'(flag_z), mz);
        chk({tag, " flag_c"}, int'(flag_c), mc);
        chk({tag, " counter"}, int'(counter), mpc);
        chk({tag, " out count"}, outs.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s out%0d", tag, i),
                (i < outs.size()) ? outs[i] : -1, expq[i]);
    endtask

    initial begin
        bit to;
        int nv, nw, r;
        logic [IW-1:0] nop;
        nop = ins(11, 0);

        for (int k = 0; k < NV; k++) begin
            for (int i = 0; i < N; i++) vecs[k].prog[i] = nop;
            vecs[k].wfrom = 15;
            vecs[k].wto = 0;
            vecs[k].nwatch = 0;
            vecs[k].nvalid = 0;
            vecs[k].out = 12;
        end
        vecs[0].prog[0] = ins(1, 5);
        vecs[0].prog[1] = ins(3, 3);
        vecs[0].prog[2] = ins(1, 7);
        vecs[0].prog[3] = ins(4, 3);
        vecs[0].prog[4] = ins(10, 0);
        vecs[0].prog[5] = ins(0, 0);
        {vecs[0].acc, vecs[0].z, vecs[0].c, vecs[0].cnt} = {32'd12, 32'd0, 32'd0, 32'd6};
        vecs[0].nvalid = 1;
        vecs[1].prog[0] = ins(1, 9);
        vecs[1].prog[1] = ins(3, 0);
        vecs[1].prog[2] = ins(4, 0);
        vecs[1].prog[3] = ins(0, 0);
        {vecs[1].acc, vecs[1].z, vecs[1].c, vecs[1].cnt} = {32'd2, 32'd0, 32'd1, 32'd4};
        vecs[2].prog[0] = ins(5, 0);
        vecs[2].prog[1] = ins(0, 0);
        {vecs[2].acc, vecs[2].z, vecs[2].c, vecs[2].cnt} = {32'd9, 32'd0, 32'd1, 32'd2};
        vecs[3].prog[0] = ins(1, 1);
        vecs[3].prog[1] = ins(3, 15);
        vecs[3].prog[2] = ins(1, 3);
        vecs[3].prog[3] = ins(5, 15);
        vecs[3].prog[4] = ins(7, 6);
        vecs[3].prog[5] = ins(6, 3);
        vecs[3].prog[6] = ins(0, 0);
        {vecs[3].acc, vecs[3].z, vecs[3].c, vecs[3].cnt} = {32'd0, 32'd1, 32'd0, 32'd7};
        {vecs[3].wfrom, vecs[3].wto, vecs[3].nwatch} = {32'd3, 32'd4, 32'd3};
        vecs[4].prog[0] = ins(0, 0);
        {vecs[4].acc, vecs[4].z, vecs[4].c, vecs[4].cnt} = {32'd0, 32'd1, 32'd0, 32'd1};
        vecs[5].prog[0] = ins(7, 2);
        vecs[5].prog[1] = ins(0, 0);
        vecs[5].prog[2] = ins(1, 1);
        {vecs[5].acc, vecs[5].z, vecs[5].c, vecs[5].cnt} = {32'd1, 32'd0, 32'd0, 32'd2};
        vecs[5].nwatch = 1;

        reset_count = 1'b1;
        run = 1'b1;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        run = 1'b0;
        step();
        reset_count = 1'b0;
        chk("rst counter", int'(counter), 0);
        chk("rst Acc", int'(Acc), 0);
        chk("rst flags", int'({flag_z, flag_c}), 0);
        chk("rst out", int'({out_data, out_valid, in_ready}), 0);
        chk("rst halted/busy", int'({halted, busy}), 0);

        for (int k = 0; k < NV; k++) begin
            load_prog(vecs[k].prog);
            run_core(300, 1'b0, to, nv, nw, vecs[k].wfrom, vecs[k].wto);
            chk($sformatf("vec%0d timeout", k), int'(to), 0);
            chk($sformatf("vec%0d Acc", k), int'(Acc), vecs[k].acc);
            chk($sformatf("vec%0d flag_z", k), int'(flag_z), vecs[k].z);
            chk($sformatf("vec%0d flag_c", k), int'(flag_c), vecs[k].c);
            chk($sformatf("vec%0d counter", k), int'(counter), vecs[k].cnt);
            chk($sformatf("vec%0d out_data", k), int'(out_data), vecs[k].out);
            chk($sformatf("vec%0d out_valid cycles", k), nv, vecs[k].nvalid);
            chk($sformatf("vec%0d watch", k), nw, vecs[k].nwatch);
            chk($sformatf("vec%0d halted", k), int'(halted), 1);
        end

        for (int i = 0; i < N; i++) prog[i] = nop;
        prog[0] = ins(9, 0);
        prog[1] = ins(10, 0);
        prog[2] = ins(0, 0);
        load_prog(prog);
        in_valid = 1'b0;
        out_ready = 1'b0;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        chk("io in_ready seen", int'(in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            chk("io in_ready held", int'(in_ready & busy), 1);
            step();
        end
        in_data = 4'hA;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("io Acc after IN", int'(Acc), 10);
        chk("io in_ready drop", int'(in_ready), 0);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        for (int i = 0; i < 3; i++) begin
            chk("io out_valid held", int'(out_valid & busy), 1);
            chk("io out_data held", int'(out_data), 10);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("io out_valid drop", int'(out_valid), 0);
        for (int i = 0; i < 20 && !halted; i++) step();
        chk("io halted counter", int'({halted, counter}), 16 + 3);

        in_data = 4'h5;
        in_valid = 1'b1;
        out_ready = 1'b0;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk("rst5 out before", int'(out_data), 5);
        reset_count = 1'b1;
        step();
        reset_count = 1'b0;
        chk("rst5 counter/Acc", int'({counter, Acc}), 0);
        chk("rst5 out_valid/out_data", int'({out_valid, out_data}), 0);
        chk("rst5 state idle", int'({busy, halted, in_ready}), 0);
        in_valid = 1'b0;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        prog_we = 1'b1;
        prog_addr = AW'(1);
        prog_data = ins(0, 0);
        step();
        prog_we = 1'b0;
        chk("wp busy", int'(busy), 1);
        in_data = 4'h6;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !halted; i++) step();
        chk("wp out_data", int'(out_data), 6);
        chk("wp counter", int'({halted, counter}), 16 + 3);

        reset_count = 1'b1;
        step();
        reset_count = 1'b0;
        macc = 0;
        mz = 0;
        mc = 0;
        for (int a = 0; a < N; a++) begin
            for (int i = 0; i < N; i++) prog[i] = nop;
            prog[0] = ins(1, $urandom_range(0, DM - 1));
            prog[1] = ins(3, a);
            prog[2] = ins(0, 0);
            model_case($sformatf("init%0d", a), 1'b0);
        end
        for (int t = 0; t < 40; t++) begin
            for (int a = 0; a < N - 1; a++) begin
                r = $urandom_range(0, 12);
                if (r > 10) r = $urandom_range(11, 15);
                if (r >= 6 && r <= 8)
                    prog[a] = ins(r, a + 1 + $urandom_range(0, 14 - a));
                else
                    prog[a] = ins(r, $urandom_range(0, N - 1));
            end
            prog[N-1] = ins(0, 0);
            for (int i = 0; i < 64; i++) inq[i] = $urandom_range(0, DM - 1);
            model_case($sformatf("rnd%0d", t), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
